// File: rtl/decipher_if.sv
// Bus bundle for the AES-128 inverse cipher: start/ciphertext in, round-key
// fetch port, plaintext/strobe/busy out.
interface decipher_if #(
    parameter int unsigned BLK_S = 128,
    parameter int unsigned KEY_S = 128,
    parameter int unsigned Nk    = 4
);
    logic             en;
    logic [BLK_S-1:0] ciphertext;
    logic [KEY_S-1:0] key;
    logic [BLK_S-1:0] plaintext;
    logic [Nk-1:0]    round_key_no;
    logic             busy;
    logic             en_o;

    // Requester side: starts blocks and serves round keys.
    modport master (
        output en, ciphertext, key,
        input  plaintext, round_key_no, busy, en_o
    );

    // Core side.
    modport slave (
        input  en, ciphertext, key,
        output plaintext, round_key_no, busy, en_o
    );
endinterface

// File: rtl/decipher.sv
// Iterative AES-128 inverse cipher. One round per clock; round keys are
// fetched by index 10 down to 0 from an external store with 1-cycle latency.
module decipher #(
    parameter int unsigned BLK_S = 128,
    parameter int unsigned KEY_S = 128,
    parameter int unsigned Nr    = 10,
    parameter int unsigned Nk    = 4
) (
    input logic       clk,
    input logic       reset,
    decipher_if.slave bus
);

    localparam int unsigned NB = BLK_S / 8;
    localparam logic [Nk-1:0] NR_IDX = Nk'(Nr);

    // ------------------------------------------------------------------
    // GF(2^8) helpers, polynomial 0x11b
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // Inverse S-box table, built at elaboration by inverting the forward
    // S-box (affine transform of the field inverse).
    function automatic logic [2047:0] gen_inv_sbox();
        logic [2047:0] t;
        logic [7:0]    inv;
        logic [7:0]    s;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            inv = gf_inv(8'(i));
            s   = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            t[{s, 3'b000} +: 8] = 8'(i);
        end
        return t;
    endfunction

    localparam logic [2047:0] INV_SBOX = gen_inv_sbox();

    // ------------------------------------------------------------------
    // Round functions
    // ------------------------------------------------------------------
    // Row r of the state rotated right by r columns.
    function automatic logic [BLK_S-1:0] inv_shift_rows(input logic [BLK_S-1:0] s);
        logic [BLK_S-1:0] o;
        for (int i = 0; i < NB; i++) begin
            o[8*i +: 8] = s[8*((i*13) % 16) +: 8];
        end
        return o;
    endfunction

    function automatic logic [BLK_S-1:0] inv_sub_bytes(input logic [BLK_S-1:0] s);
        logic [BLK_S-1:0] o;
        for (int i = 0; i < NB; i++) begin
            o[8*i +: 8] = INV_SBOX[{s[8*i +: 8], 3'b000} +: 8];
        end
        return o;
    endfunction

    // Each output row r = 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3].
    function automatic logic [BLK_S-1:0] inv_mix_columns(input logic [BLK_S-1:0] s);
        logic [BLK_S-1:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[32*c + 8*r +: 8] = gf_mul(s[32*c + 8*r +: 8], 8'h0e)
                                   ^ gf_mul(s[32*c + 8*((r+1) % 4) +: 8], 8'h0b)
                                   ^ gf_mul(s[32*c + 8*((r+2) % 4) +: 8], 8'h0d)
                                   ^ gf_mul(s[32*c + 8*((r+3) % 4) +: 8], 8'h09);
            end
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // State and control
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StFetch, StRound} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [BLK_S-1:0] state_q, state_d;
    logic [BLK_S-1:0] plaintext_q, plaintext_d;
    logic [Nk-1:0]    cnt_q, cnt_d;
    logic [Nk-1:0]    rkn_q, rkn_d;
    logic             busy_q, busy_d;
    logic             en_o_q, en_o_d;

    logic [KEY_S-1:0] rk;
    logic [BLK_S-1:0] sr_out;
    logic [BLK_S-1:0] sb_out;
    logic [BLK_S-1:0] ark_out;
    logic [BLK_S-1:0] mc_out;

    // Shared round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
    always_comb begin
        rk      = bus.key;
        sr_out  = inv_shift_rows(state_q);
        sb_out  = inv_sub_bytes(sr_out);
        ark_out = sb_out ^ rk;
        mc_out  = inv_mix_columns(ark_out);
    end

    // Next-state logic for the FSM, round counter, key index and outputs.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        plaintext_d = plaintext_q;
        cnt_d       = cnt_q;
        rkn_d       = rkn_q;
        busy_d      = busy_q;
        en_o_d      = 1'b0;

        unique case (fsm_q)
            StIdle: begin
                rkn_d = '0;
                if (bus.en) begin
                    state_d = bus.ciphertext;
                    rkn_d   = NR_IDX;
                    busy_d  = 1'b1;
                    fsm_d   = StFetch;
                end
            end
            StFetch: begin
                // RK[Nr] is in flight; request the next one.
                rkn_d = NR_IDX - 1'b1;
                cnt_d = NR_IDX;
                fsm_d = StRound;
            end
            StRound: begin
                rkn_d = (rkn_q != '0) ? rkn_q - 1'b1 : '0;
                if (cnt_q == NR_IDX) begin
                    state_d = state_q ^ rk;
                    cnt_d   = cnt_q - 1'b1;
                end else if (cnt_q == '0) begin
                    plaintext_d = ark_out;
                    en_o_d      = 1'b1;
                    busy_d      = 1'b0;
                    fsm_d       = StIdle;
                end else begin
                    state_d = mc_out;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: begin
                fsm_d  = StIdle;
                busy_d = 1'b0;
                rkn_d  = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            plaintext_q <= '0;
            cnt_q       <= '0;
            rkn_q       <= '0;
            busy_q      <= 1'b0;
            en_o_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            plaintext_q <= plaintext_d;
            cnt_q       <= cnt_d;
            rkn_q       <= rkn_d;
            busy_q      <= busy_d;
            en_o_q      <= en_o_d;
        end
    end

    assign bus.plaintext    = plaintext_q;
    assign bus.round_key_no = rkn_q;
    assign bus.busy         = busy_q;
    assign bus.en_o         = en_o_q;

endmodule

// File: tb/tb_decipher.sv
// Self-checking bench for the AES-128 inverse cipher: FIPS vectors, key-index
// protocol, ignored starts, back-to-back, mid-operation reset, random blocks.
module tb_decipher;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decipher_if #(.BLK_S(128), .KEY_S(128), .Nk(4)) bus ();

    decipher #(.BLK_S(128), .KEY_S(128), .Nr(10), .Nk(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] sb[$];
    logic [127:0] rk [0:10];
    logic [7:0]   sbox_t [256];
    int rk_oob    = 0;
    int en_o_seen = 0;
    int en_o_dbl  = 0;
    logic en_o_prev = 1'b0;

    // Round-key store with 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.round_key_no > 4'd10) rk_oob <= rk_oob + 1;
        bus.key <= rk[(bus.round_key_no > 4'd10) ? 4'd0 : bus.round_key_no];
    end

    // en_o pulse monitor.
    always @(negedge clk) begin
        if (bus.en_o === 1'b1) en_o_seen <= en_o_seen + 1;
        if (bus.en_o === 1'b1 && en_o_prev) en_o_dbl <= en_o_dbl + 1;
        en_o_prev <= (bus.en_o === 1'b1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (forward cipher) ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3)
                      ^ m_rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] rev(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [1407:0] o;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {24'h0, rcon};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) o[32*i +: 32] = w[i];
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [1407:0] ks;
        logic [127:0]  s, t;
        ks = expand(k);
        s  = pt ^ ks[127:0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[8*i +: 8] = sbox_t[s[8*((i*5) % 16) +: 8]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++)
                        s[32*c + 8*j +: 8] = m_mul(t[32*c + 8*j +: 8], 8'h02)
                                           ^ m_mul(t[32*c + 8*((j+1) % 4) +: 8], 8'h03)
                                           ^ t[32*c + 8*((j+2) % 4) +: 8]
                                           ^ t[32*c + 8*((j+3) % 4) +: 8];
            end else begin
                s = t;
            end
            s = s ^ ks[128*r +: 128];
        end
        return s;
    endfunction

    task automatic load_keys(input logic [127:0] k);
        logic [1407:0] ks;
        ks = expand(k);
        for (int r = 0; r <= 10; r++) rk[r] = ks[128*r +: 128];
    endtask

    // Call at a negedge (cycle 0); returns at the negedge of cycle 1.
    task automatic start(input logic [127:0] ct, input logic [127:0] exp);
        bus.en = 1'b1;
        bus.ciphertext = ct;
        sb.push_back(exp);
        @(negedge clk);
        bus.en = 1'b0;
        bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Waits (bounded) for en_o, then scores plaintext and latency.
    task automatic wait_done(input string tag);
        int lat;
        logic [127:0] exp;
        lat = 1;
        while (bus.en_o !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_en_o"}, bus.en_o, 1);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        if (bus.en_o === 1'b1) begin
            check({tag, "_pt"}, bus.plaintext, exp);
            check({tag, "_lat"}, lat, 13);
        end
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [127:0] k, pt;
        int stray;
        reset = 1'b1;
        bus.en = 1'b0;
        bus.ciphertext = '0;
        build_sbox();
        load_keys(rev(C1_KEY));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pt", bus.plaintext, 0);
        check("rst_rkn", bus.round_key_no, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_en_o", bus.en_o, 0);
        reset = 1'b0;
        @(negedge clk);

        // C.1 with full protocol check and ignored starts at cycles 3 and 7.
        bus.en = 1'b1;
        bus.ciphertext = rev(C1_CT);
        sb.push_back(rev(C1_PT));
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            check($sformatf("c1_busy_%0d", c), bus.busy, (c <= 12) ? 1 : 0);
            check($sformatf("c1_rkn_%0d", c), bus.round_key_no, (c <= 11) ? 11 - c : 0);
            check($sformatf("c1_en_o_%0d", c), bus.en_o, (c == 13) ? 1 : 0);
            bus.en = (c == 3 || c == 7) ? 1'b1 : 1'b0;
            bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
            if (c == 13) begin
                check("c1_pt", bus.plaintext, sb.pop_front());
                // Back-to-back: FIPS-197 B accepted in the en_o cycle.
                load_keys(rev(B_KEY));
                bus.en = 1'b1;
                bus.ciphertext = rev(B_CT);
                sb.push_back(rev(B_PT));
            end
        end
        for (int c = 14; c <= 26; c++) begin
            @(negedge clk);
            bus.en = 1'b0;
            check($sformatf("b_en_o_%0d", c), bus.en_o, (c == 26) ? 1 : 0);
            if (c == 26) check("b_pt", bus.plaintext, sb.pop_front());
        end

        // Reset in cycle 6 of a C.1 run.
        load_keys(rev(C1_KEY));
        start(rev(C1_CT), rev(C1_PT));
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("arst_busy", bus.busy, 0);
        check("arst_en_o", bus.en_o, 0);
        check("arst_rkn", bus.round_key_no, 0);
        check("arst_pt", bus.plaintext, 0);
        void'(sb.pop_back());
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.en_o !== 1'b0) stray++;
        end
        check("arst_no_en_o", stray, 0);
        start(rev(C1_CT), rev(C1_PT));
        wait_done("c1_after_rst");

        // Random blocks, back-to-back.
        for (int n = 0; n < 1000; n++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            load_keys(k);
            start(aes_enc(k, pt), pt);
            wait_done("rand");
        end

        repeat (3) @(negedge clk);
        check("en_o_count", en_o_seen, 1003);
        check("en_o_double", en_o_dbl, 0);
        check("rk_index_oob", rk_oob, 0);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
